// File: rtl/alu_stream_unit.sv
// Two-stage handshaked ALU: s1 holds the request, s2 holds the computed response.
// Optional sticky flag accumulation is enabled by defining ALU_STICKY_FLAGS_EN.
module alu_stream_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic [3:0]       resp_flags,
    output logic             resp_err,
    output logic [CNT_W-1:0] resp_count,
    input  logic             sticky_clr,
    output logic [3:0]       sticky_flags
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101
    } op_e;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // producers hold valid and data stable until that edge.

    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_result;
    logic [3:0]       r_s2_flags;
    logic             r_s2_err;
    logic [CNT_W-1:0] r_count;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_resp_hs;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_ovf;
    logic             w_err;
    logic [3:0]       w_flags;

    assign w_adv2    = ~r_s2_valid | resp_ready;
    assign w_adv1    = ~r_s1_valid | w_adv2;
    assign req_ready = w_adv1 & reset;
    assign w_resp_hs = r_s2_valid & resp_ready;

    // Subtraction is a + ~b + 1, so carry-out set means no borrow.
    assign w_add = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign w_sub = {1'b0, r_s1_a} + {1'b0, ~r_s1_b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        w_err    = 1'b0;
        case (r_s1_op)
            OP_ADD: begin
                w_result = w_add[WIDTH-1:0];
                w_carry  = w_add[WIDTH];
                w_ovf    = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                           (w_add[WIDTH-1] != r_s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_result = w_sub[WIDTH-1:0];
                w_carry  = w_sub[WIDTH];
                w_ovf    = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                           (w_sub[WIDTH-1] != r_s1_a[WIDTH-1]);
            end
            OP_AND: w_result = r_s1_a & r_s1_b;
            OP_OR:  w_result = r_s1_a | r_s1_b;
            OP_XOR: w_result = r_s1_a ^ r_s1_b;
            OP_SLT: w_result = {{(WIDTH-1){1'b0}}, ($signed(r_s1_a) < $signed(r_s1_b))};
            default: w_err = 1'b1;
        endcase
    end

    // Illegal ops report all-zero flags, including Z.
    assign w_flags = w_err ? 4'b0000
                           : {w_result[WIDTH-1], (w_result == '0), w_carry, w_ovf};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_flags  <= '0;
            r_s2_err    <= 1'b0;
            r_count     <= '0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= req_valid;
                if (req_valid) begin
                    r_s1_op <= req_op;
                    r_s1_a  <= req_a;
                    r_s1_b  <= req_b;
                end
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_result <= w_result;
                    r_s2_flags  <= w_flags;
                    r_s2_err    <= w_err;
                end
            end
            if (w_resp_hs) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign resp_valid  = r_s2_valid;
    assign resp_result = r_s2_result;
    assign resp_flags  = r_s2_flags;
    assign resp_err    = r_s2_err;
    assign resp_count  = r_count;

`ifdef ALU_STICKY_FLAGS_EN
    logic [3:0] r_sticky;

    // A clear coinciding with a delivery keeps only that delivery's flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sticky <= 4'b0000;
        end else if (sticky_clr) begin
            r_sticky <= w_resp_hs ? r_s2_flags : 4'b0000;
        end else if (w_resp_hs) begin
            r_sticky <= r_sticky | r_s2_flags;
        end
    end

    assign sticky_flags = r_sticky;
`else
    logic w_unused_sticky_clr;

    assign w_unused_sticky_clr = sticky_clr;
    assign sticky_flags        = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_stream_unit.sv
// Scoreboard bench for alu_stream_unit: driver pushes model results, negedge monitor pops.
module tb_alu_stream_unit;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;
  localparam int EW    = WIDTH + 5;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic [3:0]       resp_flags;
  logic             resp_err;
  logic [CNT_W-1:0] resp_count;
  logic             sticky_clr;
  logic [3:0]       sticky_flags;

  alu_stream_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_flags(resp_flags), .resp_err(resp_err), .resp_count(resp_count),
    .sticky_clr(sticky_clr), .sticky_flags(sticky_flags)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_count = '0;
  logic [3:0]       exp_sticky = 4'b0000;
  logic             rst_prev = 1'b0;
  logic             hold_prev = 1'b0;
  logic [EW-1:0]    hold_data = '0;
  logic             acc = 1'b0;
  logic             smp_hs = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: packed {result, N, Z, C, V, err}
  function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
    longint           sa, sb, s, smax, smin;
    longint unsigned  ua, ub;
    logic [WIDTH-1:0] res;
    logic             c, v;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ua   = longint'(a);
    ub   = longint'(b);
    smax = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin = -(longint'(1) <<< (WIDTH - 1));
    c = 1'b0;
    v = 1'b0;
    res = '0;
    case (op)
      3'd0: begin
        res = a + b;
        c = (ua + ub) >= (longint'(1) <<< WIDTH);
        s = sa + sb;
        v = (s > smax) || (s < smin);
      end
      3'd1: begin
        res = a - b;
        c = (ua >= ub);
        s = sa - sb;
        v = (s > smax) || (s < smin);
      end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = (sa < sb) ? 1 : 0;
      default: return {{WIDTH{1'b0}}, 4'b0000, 1'b1};
    endcase
    return {res, res[WIDTH-1], (res == 0), c, v, 1'b0};
  endfunction

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    if (rst_prev) begin
      chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rst_resp_count", {48'd0, resp_count}, 64'd0);
      chk("rst_sticky", {60'd0, sticky_flags}, 64'd0);
    end
    if (reset) begin
      chk("resp_count", {48'd0, resp_count}, {48'd0, exp_count});
      chk("sticky", {60'd0, sticky_flags}, {60'd0, exp_sticky});
      if (hold_prev) begin
        chk("hold_valid", {63'd0, resp_valid}, 64'd1);
        chk("hold_data", {27'd0, resp_result, resp_flags, resp_err}, {27'd0, hold_data});
      end
      if (resp_valid && resp_ready) begin
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
          chk("spurious_resp", {63'd0, resp_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", {27'd0, resp_result, resp_flags, resp_err}, {27'd0, e});
`ifdef ALU_STICKY_FLAGS_EN
          exp_sticky = sticky_clr ? e[4:1] : (exp_sticky | e[4:1]);
`endif
        end
        exp_count = exp_count + 1'b1;
      end else begin
`ifdef ALU_STICKY_FLAGS_EN
        if (sticky_clr) exp_sticky = 4'b0000;
`endif
      end
      hold_prev = resp_valid && !resp_ready;
      hold_data = {resp_result, resp_flags, resp_err};
    end else begin
      exp_q.delete();
      exp_count  = '0;
      exp_sticky = 4'b0000;
      hold_prev  = 1'b0;
    end
    rst_prev = !reset;
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    smp_hs = resp_valid && resp_ready && reset;
    acc = req_valid && req_ready;
    if (acc) exp_q.push_back(model(req_op, req_a, req_b));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int guard;
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!acc && guard < 50);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || resp_valid) && guard < 50) begin
      tick();
      guard++;
    end
    chk("drain_empty", {32'd0, exp_q.size()}, 64'd0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) tick();
    reset = 1'b1;
  endtask

  task automatic run_random(input int n_req, input int ready_pct);
    int sent;
    int guard;
    sent = 0;
    guard = 0;
    while (sent < n_req && guard < 20000) begin
      if (!req_valid && $urandom_range(0, 3) != 0) begin
        req_valid = 1'b1;
        req_op = 3'($urandom_range(0, 7));
        req_a = rand_operand();
        req_b = rand_operand();
      end
      resp_ready = ($urandom_range(0, 99) < ready_pct);
      sticky_clr = ($urandom_range(0, 15) == 0);
      tick();
      if (acc) begin
        req_valid = 1'b0;
        sent++;
      end
      guard++;
    end
    sticky_clr = 1'b0;
    chk("random_sent", 64'(sent), 64'(n_req));
  endtask

  logic [2:0]       bp_op[4];
  logic [WIDTH-1:0] bp_a[4];
  logic [WIDTH-1:0] bp_b[4];

  initial begin
    int idx;
    int hs;
    reset = 1'b0;
    req_valid = 1'b1;
    req_op = 3'd0;
    req_a = 32'd3;
    req_b = 32'd4;
    resp_ready = 1'b1;
    sticky_clr = 1'b0;

    // 1: reset held with a request pending, then first accept right after release
    repeat (3) tick();
    chk("rst_hold_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_hold_valid", {63'd0, resp_valid}, 64'd0);
    reset = 1'b1;
    tick();
    chk("first_accept", {63'd0, acc}, 64'd1);
    req_valid = 1'b0;
    drain();

    // 2: ADD carry/overflow with latency check
    send(3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("lat_s1", {63'd0, resp_valid}, 64'd0);
    tick();
    chk("lat_s2", {63'd0, resp_valid}, 64'd1);
    chk("add_carry_res", {32'd0, resp_result}, 64'h0);
    chk("add_carry_flags", {60'd0, resp_flags}, 64'b0110);
    drain();
    send(3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    tick();
    chk("add_ovf_res", {32'd0, resp_result}, 64'h8000_0000);
    chk("add_ovf_flags", {60'd0, resp_flags}, 64'b1001);
    drain();

    // 3: SUB / SLT / illegal op through the scoreboard
    send(3'd1, 32'd5, 32'd5);
    send(3'd1, 32'd0, 32'd1);
    send(3'd5, 32'hFFFF_FFFF, 32'd1);
    send(3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
    send(3'd6, 32'h1, 32'h1);
    drain();

    // 4: backpressure with four back-to-back requests
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      bp_op[i] = 3'($urandom_range(0, 5));
      bp_a[i] = rand_operand();
      bp_b[i] = rand_operand();
    end
    resp_ready = 1'b0;
    idx = 0;
    req_valid = 1'b1;
    req_op = bp_op[0];
    req_a = bp_a[0];
    req_b = bp_b[0];
    repeat (5) begin
      tick();
      if (acc) begin
        idx++;
        req_op = bp_op[idx];
        req_a = bp_a[idx];
        req_b = bp_b[idx];
      end
    end
    chk("bp_accepts", 64'(idx), 64'd2);
    chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
    resp_ready = 1'b1;
    hs = 0;
    repeat (4) begin
      tick();
      if (smp_hs) hs++;
      if (acc) begin
        idx++;
        if (idx < 4) begin
          req_op = bp_op[idx];
          req_a = bp_a[idx];
          req_b = bp_b[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    chk("bp_all_accepted", 64'(idx), 64'd4);
    chk("bp_back_to_back", 64'(hs), 64'd4);
    drain();
    chk("bp_resp_count", {48'd0, resp_count}, 64'd4);

    // 5: reset with two ops in flight
    resp_ready = 1'b0;
    send(3'd0, 32'd1, 32'd2);
    send(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
    reset = 1'b0;
    tick();
    chk("flight_rst_valid", {63'd0, resp_valid}, 64'd0);
    reset = 1'b1;
    resp_ready = 1'b1;
    repeat (4) tick();
    chk("flight_no_stale", {63'd0, resp_valid}, 64'd0);

    // 6: sticky flags accumulation and clear
    send(3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    send(3'd1, 32'd5, 32'd5);
    drain();
`ifdef ALU_STICKY_FLAGS_EN
    chk("sticky_acc", {60'd0, sticky_flags}, 64'b1111);
`else
    chk("sticky_acc", {60'd0, sticky_flags}, 64'b0000);
`endif
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("sticky_clr", {60'd0, sticky_flags}, 64'b0000);

    // randomized traffic with varying backpressure
    run_random(150, 100);
    run_random(150, 40);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
